router_pkt_src: RTL and testbench

- Upstream packet source for router_top. Drives router_top's pkt_valid/data_in/busy/err interface.
- Accepts a packet request (destination address, payload length) plus a valid/ready payload byte stream.
- Emits header, then payload, then a parity byte, holding data whenever the router asserts busy.
- Reports each packet's completion and the router's parity-error verdict. Sits between the traffic generator/host logic and router_top.

---
 rtl/router_pkg.sv | 11 +
 rtl/router_parity_acc.sv | 17 +
 rtl/router_pkt_src.sv | 123 ++++++++++++
 tb/tb_router_pkt_src.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared state encoding, field widths and header assembly for the router packet source
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W = 6;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;
  typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, CHK} state_t;
  function automatic logic [DATA_W-1:0] make_hdr(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction
endpackage

// File: rtl/router_parity_acc.sv
// router_parity_acc: 8-bit XOR accumulator with clear/load/accumulate priority
module router_parity_acc
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              load,
  input  logic              acc,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  // running parity: clear wins over load, load over accumulate
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) q <= '0;
    else q <= clear ? '0 : load ? din : acc ? q ^ din : q;
endmodule

// File: rtl/router_pkt_src.sv
// router_pkt_src: packet source feeding router_top (header, payload, parity, err verdict); ROUTER_PKT_SRC_STATS_EN adds pkt_cnt/err_cnt
module router_pkt_src
  import router_pkg::*;
#(
  parameter int ERR_WAIT = 4,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_reject,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic              done,
  output logic              pkt_err
`ifdef ROUTER_PKT_SRC_STATS_EN
  ,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
`endif
);
  localparam int WW = $clog2(ERR_WAIT + 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q, rem;
  logic [WW-1:0] wait_cnt;
  logic flag;
  logic [DATA_W-1:0] parity, hdr;
  logic req_ok, accept, fin;
  assign hdr = make_hdr(len_q, addr_q);
  assign req_ok = req_addr != INVALID_ADDR && req_len != '0;
  assign req_ready = state == IDLE;
  assign accept = req_ready && req_valid && req_ok;
  assign fin = state == CHK && wait_cnt == WW'(1);
  router_parity_acc u_par (
    .clock (clock),
    .resetn(resetn),
    .clear (state == IDLE),
    .load  (state == HDR && !busy),
    .acc   (pl_ready),
    .din   (state == HDR ? hdr : pl_data),
    .q     (parity)
  );
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // next state and the byte presented to the router in each state
  always_comb begin
    state_n = state;
    pkt_valid = 1'b0;
    pkt_data = '0;
    pl_ready = 1'b0;
    case (state)
      IDLE: state_n = accept ? HDR : IDLE;
      HDR: begin
        pkt_valid = 1'b1;
        pkt_data = hdr;
        state_n = busy ? HDR : PLD;
      end
      PLD: begin
        pkt_valid = pl_valid;
        pkt_data = pl_data;
        pl_ready = pl_valid && !busy;
        state_n = pl_ready && rem == LEN_W'(1) ? PAR : PLD;
      end
      PAR: begin
        pkt_data = parity;
        state_n = busy ? PAR : CHK;
      end
      CHK: state_n = fin ? IDLE : CHK;
      default: state_n = IDLE;
    endcase
  end
  // request latch, byte countdown, err window and one-cycle status pulses
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      addr_q <= '0;
      len_q <= '0;
      rem <= '0;
      wait_cnt <= '0;
      flag <= 1'b0;
      req_reject <= 1'b0;
      done <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      req_reject <= req_ready && req_valid && !req_ok;
      done <= fin;
      pkt_err <= fin && (flag || err);
      if (accept) begin
        addr_q <= req_addr;
        len_q <= req_len;
      end
      if (state == HDR && !busy) rem <= len_q;
      else if (pl_ready) rem <= rem - LEN_W'(1);
      if (state == PAR && !busy) begin
        wait_cnt <= WW'(ERR_WAIT);
        flag <= 1'b0;
      end else if (state == CHK) begin
        wait_cnt <= wait_cnt - WW'(1);
        flag <= flag || err;
      end
    end
`ifdef ROUTER_PKT_SRC_STATS_EN
  // saturating counters, updated on the edge that raises done
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (fin) begin
      pkt_cnt <= &pkt_cnt ? pkt_cnt : pkt_cnt + CNT_W'(1);
      if (flag || err) err_cnt <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: randomized scoreboard bench for router_pkt_src
module tb_router_pkt_src;
  localparam int ERR_WAIT = 4;
  logic clock = 0, resetn = 0, req_valid = 0, pl_valid = 0, busy = 0, err = 0;
  logic [1:0] req_addr = 0;
  logic [5:0] req_len = 0;
  logic [7:0] pl_data = 0;
  logic req_ready, req_reject, pl_ready, pkt_valid, done, pkt_err;
  logic [7:0] pkt_data;
`ifdef ROUTER_PKT_SRC_STATS_EN
  logic [15:0] pkt_cnt, err_cnt;
  int m_pkt = 0, m_err = 0;
`endif
  int checks = 0, errors = 0, rej_exp = 0, rej_seen = 0;
  logic [9:0] bq[$];
  logic [7:0] pq[$];
  logic eq[$];
  logic [7:0] pay[64];
  bit par_pending = 0;
  logic [9:0] mon_e;
  logic mon_err;

  router_pkt_src #(.ERR_WAIT(ERR_WAIT), .CNT_W(16)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_reject(req_reject),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .busy(busy), .err(err), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .done(done), .pkt_err(pkt_err)
`ifdef ROUTER_PKT_SRC_STATS_EN
    , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rb(input int bp);
    return $urandom_range(99) < bp;
  endfunction

  // monitor: pops the scoreboard whenever the DUT shows a transfer, parity or done
  always @(negedge clock) if (resetn) begin
    if (par_pending) begin
      chk("par_valid", pkt_valid, 0);
      if (pq.size() == 0) chk("parity_missing", 1, 0);
      else chk("parity", pkt_data, pq.pop_front());
      par_pending = 0;
    end
    if (pkt_valid) begin
      if (bq.size() == 0) chk("spurious_byte", 1, 0);
      else begin
        chk("pl_ready", pl_ready, bq[0][8] && !busy);
        if (!busy) begin
          mon_e = bq.pop_front();
          chk("byte", pkt_data, mon_e[7:0]);
          par_pending = mon_e[9];
        end else chk("hold_data", pkt_data, bq[0][7:0]);
      end
    end
    if (done) begin
      if (eq.size() == 0) chk("spurious_done", 1, 0);
      else begin
        mon_err = eq.pop_front();
        chk("pkt_err", pkt_err, mon_err);
`ifdef ROUTER_PKT_SRC_STATS_EN
        m_pkt++;
        m_err += int'(mon_err);
        chk("pkt_cnt", pkt_cnt, m_pkt);
        chk("err_cnt", err_cnt, m_err);
`endif
      end
    end
    if (req_reject) rej_seen++;
  end

  // reference model: header {len,addr}, payload bytes, XOR parity of all of them
  task automatic prep(input logic [1:0] a, input logic [5:0] l, input bit fixed, input int mode);
    logic [7:0] p;
    p = {l, a};
    bq.push_back({2'b00, l, a});
    for (int i = 0; i < int'(l); i++) begin
      pay[i] = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
      p ^= pay[i];
      bq.push_back({i == int'(l) - 1, 1'b1, pay[i]});
    end
    pq.push_back(p);
    eq.push_back(mode == 2);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 200) chk("req_ready_timeout", 0, 1);
  endtask

  // mode: 0 no err, 1 err noise before parity (ignored), 2 err in 2nd cycle after parity
  task automatic send(input logic [1:0] a, input logic [5:0] l, input bit fixed, input int mode, input int bp, input int hold);
    int idx, cyc, n;
    logic acc, b;
    wait_ready();
    if (a == 2'd3 || l == 6'd0) begin
      rej_exp++;
      req_valid = 1; req_addr = a; req_len = l;
      @(posedge clock); #1;
      req_valid = 0;
      @(negedge clock);
      chk("reject_pulse", req_reject, 1);
      chk("reject_idle", req_ready, 1);
      @(posedge clock); #1;
      chk("reject_one_cycle", req_reject, 0);
      return;
    end
    prep(a, l, fixed, mode);
    req_valid = 1; req_addr = a; req_len = l;
    @(posedge clock); #1;
    req_valid = 0;
    chk("hdr_latency", pkt_valid, 1);
    pl_valid = 1; pl_data = pay[0];
    idx = 0; cyc = 0;
    while (idx < int'(l) && cyc < 2000) begin
      busy = hold > 0 ? (cyc >= 1 && cyc <= hold) : rb(bp);
      err = mode == 1 ? rb(50) : 1'b0;
      @(negedge clock);
      acc = pl_ready;
      @(posedge clock); #1;
      if (acc) begin
        idx++;
        if (idx < int'(l)) pl_data = pay[idx];
      end
      cyc++;
    end
    if (cyc == 2000) chk("payload_timeout", idx, l);
    pl_valid = 0; err = 0;
    n = 0;
    do begin
      busy = rb(bp); b = busy;
      @(posedge clock); #1;
      n++;
    end while (b && n < 100);
    for (int k = 1; k <= ERR_WAIT; k++) begin
      busy = rb(bp);
      err = mode == 2 && k == 2;
      @(posedge clock); #1;
    end
    err = 0; busy = 0;
    @(negedge clock);
    chk("done_timing", done, 1);
  endtask

  initial begin
    int idx;
    logic acc;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_pkt_data", pkt_data, 0);
    chk("rst_done", done, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_req_reject", req_reject, 0);
    chk("rst_pl_ready", pl_ready, 0);
    @(posedge clock); #1;
    resetn = 1;
    @(negedge clock);
    send(2'd1, 6'd3, 1, 0, 0, 0);
    send(2'd1, 6'd3, 1, 0, 0, 2);
    send(2'd3, 6'd5, 0, 0, 0, 0);
    send(2'd2, 6'd0, 0, 0, 0, 0);
    send(2'd1, 6'd3, 1, 2, 0, 0);
    send(2'd2, 6'd63, 0, 1, 30, 0);
    send(2'd0, 6'd1, 0, 0, 40, 0);
    wait_ready();
    prep(2'd1, 6'd20, 0, 0);
    req_valid = 1; req_addr = 2'd1; req_len = 6'd20;
    @(posedge clock); #1;
    req_valid = 0; busy = 0; pl_valid = 1; pl_data = pay[0]; idx = 0;
    repeat (6) begin
      @(negedge clock);
      acc = pl_ready;
      @(posedge clock); #1;
      if (acc) begin
        idx++;
        pl_data = pay[idx];
      end
    end
    #2 resetn = 0;
    #1;
    chk("midrst_pkt_valid", pkt_valid, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_done", done, 0);
    bq.delete(); pq.delete(); eq.delete();
    pl_valid = 0;
`ifdef ROUTER_PKT_SRC_STATS_EN
    m_pkt = 0; m_err = 0;
`endif
    @(posedge clock); #1;
    resetn = 1;
    send(2'd0, 6'd1, 0, 0, 0, 0);
    repeat (30) begin
      logic [1:0] a;
      logic [5:0] l;
      a = 2'($urandom_range(3));
      l = $urandom_range(3) == 0 ? 6'($urandom_range(63)) : 6'($urandom_range(8));
      send(a, l, 0, int'($urandom_range(2)), int'($urandom_range(50)), 0);
    end
    repeat (10) @(posedge clock);
    #1;
    chk("queues_empty", bq.size() + pq.size() + eq.size(), 0);
    chk("reject_count", rej_seen, rej_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
